// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared constants, types and helpers for the adder library
package adder_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_GROUP = 8;
    localparam int GRP_W         = DEFAULT_GROUP;

    typedef struct packed {
        logic [GRP_W-1:0] sum;
        logic             cout;
    } group_result_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/cla_group.sv
// rtl/cla_group.sv - combinational GROUP-bit carry-lookahead slice
module cla_group
    import adder_pkg::*;
#(
    parameter int GROUP = DEFAULT_GROUP
) (
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    input  logic             ci,
    output logic [GROUP-1:0] s,
    output logic             co
);

    logic [GROUP-1:0] g;
    logic [GROUP-1:0] p;
    logic [GROUP:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    // Each carry is the flat sum-of-products of generates and the carry-in,
    // so no carry depends on a lower-order carry signal.
    always_comb begin
        logic pp;
        c    = '0;
        c[0] = ci;
        for (int i = 0; i < GROUP; i++) begin
            c[i+1] = g[i];
            pp     = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                c[i+1] = c[i+1] | (pp & g[j]);
                pp     = pp & p[j];
            end
            c[i+1] = c[i+1] | (pp & ci);
        end
    end

    assign s  = p ^ c[GROUP-1:0];
    assign co = c[GROUP];

endmodule

// File: rtl/pipelined_cla_adder.sv
// rtl/pipelined_cla_adder.sv - pipelined CLA adder, one slice per stage; ADDSUB_EN adds Sub
module pipelined_cla_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int GROUP = DEFAULT_GROUP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
`ifdef ADDSUB_EN
    input  logic             Sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
);

    localparam int STAGES = WIDTH / GROUP;

    if (WIDTH % GROUP != 0) begin : g_bad_width
        $error("WIDTH must be a multiple of GROUP");
    end

    logic             adv;
    logic [WIDTH-1:0] a_src [STAGES+1];
    logic [WIDTH-1:0] b_src [STAGES+1];
    logic [WIDTH-1:0] s_src [STAGES+1];
    logic             c_src [STAGES+1];
    logic             v_src [STAGES+1];

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    assign a_src[0] = A;
    assign s_src[0] = '0;
    assign v_src[0] = in_valid;
`ifdef ADDSUB_EN
    // Inverting B at entry means the skew chain already carries ~B upward.
    assign b_src[0] = Sub ? ~B : B;
    assign c_src[0] = Sub | Cin;
`else
    assign b_src[0] = B;
    assign c_src[0] = Cin;
`endif

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [GROUP-1:0] grp_sum;
        logic             grp_cout;
        logic [WIDTH-1:0] sum_next;
        logic [WIDTH-1:0] a_q;
        logic [WIDTH-1:0] b_q;
        logic [WIDTH-1:0] s_q;
        logic             c_q;
        logic             v_q;

        cla_group #(.GROUP(GROUP)) u_cla (
            .a  (a_src[k][k*GROUP +: GROUP]),
            .b  (b_src[k][k*GROUP +: GROUP]),
            .ci (c_src[k]),
            .s  (grp_sum),
            .co (grp_cout)
        );

        // Lower groups ride along unchanged; this stage fills in its own group.
        always_comb begin
            sum_next                    = s_src[k];
            sum_next[k*GROUP +: GROUP]  = grp_sum;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                a_q <= '0;
                b_q <= '0;
                s_q <= '0;
                c_q <= 1'b0;
                v_q <= 1'b0;
            end else if (adv) begin
                a_q <= a_src[k];
                b_q <= b_src[k];
                s_q <= sum_next;
                c_q <= grp_cout;
                v_q <= v_src[k];
            end
        end

        assign a_src[k+1] = a_q;
        assign b_src[k+1] = b_q;
        assign s_src[k+1] = s_q;
        assign c_src[k+1] = c_q;
        assign v_src[k+1] = v_q;
    end

    assign out_valid = v_src[STAGES];
    assign Sum       = s_src[STAGES];
    assign Cout      = c_src[STAGES];

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// tb/tb_pipelined_cla_adder.sv - scoreboard bench for pipelined_cla_adder (WIDTH=16, GROUP=4)
module tb_pipelined_cla_adder;

    localparam int W      = 16;
    localparam int G      = 4;
    localparam int STAGES = W / G;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Cin;
    logic         Sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] Sum;
    logic         Cout;

    logic [W:0]   exp_in;
    logic [W:0]   sb_q [$];
    int           checks = 0;
    int           errors = 0;

    pipelined_cla_adder #(.WIDTH(W), .GROUP(G)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
`ifdef ADDSUB_EN
        .Sub       (Sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Sum       (Sum),
        .Cout      (Cout)
    );

    always #5 clk = ~clk;

    // Scoreboard push: reset flushes everything in flight.
    always @(negedge clk) begin
        #3;
        if (rst === 1'b1) begin
            sb_q.delete();
        end else if (in_valid === 1'b1 && in_ready === 1'b1) begin
            sb_q.push_back(exp_in);
        end
    end

    // Monitor: compare every output transfer against the oldest expectation.
    always @(negedge clk) begin
        logic [W:0] e;
        #2;
        if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result: got %h/%b, required no output", Sum, Cout);
            end else begin
                e = sb_q.pop_front();
                if ({Cout, Sum} !== e) begin
                    errors++;
                    $display("FAIL result: got %h/%b, required %h/%b", Sum, Cout, e[W-1:0], e[W]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input logic [W:0] e);
        int n;
        n = 0;
        @(negedge clk);
        A = a; B = b; Cin = c; exp_in = e; in_valid = 1'b1;
        #4;
        while (in_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            #4;
            n++;
        end
        if (in_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready=%b, required 1", in_ready);
        end
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    initial begin
        int lat;
        rst = 1'b1; in_valid = 1'b1; A = 16'h1111; B = 16'h2222; Cin = 1'b1;
        Sub = 1'b0; out_ready = 1'b1; exp_in = '0;

        // Reset held 2 cycles with in_valid high
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_sum", 32'(Sum), 32'd0);
        check("reset_cout", 32'(Cout), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        idle(6);

        // Full ripple and latency
        send(16'hFFFF, 16'h0001, 1'b0, {1'b1, 16'h0000});
        lat = 0;
        for (int i = 1; i <= 10 && lat == 0; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            if (out_valid === 1'b1) lat = i;
        end
        check("ripple_latency", 32'(lat), 32'(STAGES));
        idle(4);

        // Back-to-back, then backpressure with the pipe full
        send(16'h1234, 16'h4321, 1'b1, {1'b0, 16'h5556});
        send(16'hFFFF, 16'hFFFF, 1'b0, {1'b1, 16'hFFFE});
        send(16'hA5A5, 16'h5A5A, 1'b1, {1'b1, 16'h0000});
        send(16'h0000, 16'h0000, 1'b0, {1'b0, 16'h0000});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b0; out_ready = 1'b0;
            #1;
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_sum", 32'(Sum), 32'h5556);
            check("stall_cout", 32'(Cout), 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        idle(8);
        check("drain_empty", 32'(sb_q.size()), 32'd0);

        // Reset with 3 transactions in flight
        send(16'h0101, 16'h0202, 1'b0, {1'b0, 16'h0303});
        send(16'h0404, 16'h0505, 1'b0, {1'b0, 16'h0909});
        send(16'h0606, 16'h0707, 1'b0, {1'b0, 16'h0D0D});
        @(negedge clk);
        in_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midreset_out_valid", 32'(out_valid), 32'd0);
        check("midreset_sum", 32'(Sum), 32'd0);
        idle(8);

`ifdef ADDSUB_EN
        @(negedge clk);
        Sub = 1'b1;
        send(16'h0005, 16'h0007, 1'b1, {1'b0, 16'hFFFE});
        @(negedge clk);
        in_valid = 1'b0; Sub = 1'b0;
        idle(8);
`endif

        // Random traffic with random backpressure
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            A = W'($urandom);
            B = W'($urandom);
            Cin = 1'($urandom_range(0, 1));
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            exp_in = {1'b0, A} + {1'b0, B} + {{W{1'b0}}, Cin};
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        idle(10);
        check("final_empty", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
